// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-requester round-robin arbiter in front of a single-port data memory
// Fixed IDLE -> ACCESS -> RESP sequence: one access per three cycles, ack pulsed in RESP.
module data_memory_arbiter #(
    parameter int WORDSIZE = 64,
    parameter int ADDRW    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                we0,
    input  logic [ADDRW-1:0]    addr0,
    input  logic [WORDSIZE-1:0] wdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic [ADDRW-1:0]    addr1,
    input  logic [WORDSIZE-1:0] wdata1,
    output logic                ack0,
    output logic                ack1,
    output logic [WORDSIZE-1:0] rdata,
    output logic                busy,
    output logic [ADDRW-1:0]    addr,
    output logic [WORDSIZE-1:0] data_input,
    output logic                write_enable,
    output logic                read,
    input  logic [WORDSIZE-1:0] data_output
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]          r_state;
    logic                r_we;
    logic [ADDRW-1:0]    r_addr;
    logic [WORDSIZE-1:0] r_wdata;
    logic                r_gnt;
    logic                r_last;
    logic [WORDSIZE-1:0] r_rdata;

    logic                w_pick1;
    logic                w_access;

    // r_last = 1 means requester 1 was granted last, so a tie goes to requester 0
    assign w_pick1  = req1 & (~req0 | ~r_last);
    assign w_access = (r_state == S_ACCESS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_gnt   <= w_pick1;
                        r_last  <= w_pick1;
                        r_we    <= w_pick1 ? we1 : we0;
                        r_addr  <= w_pick1 ? addr1 : addr0;
                        r_wdata <= w_pick1 ? wdata1 : wdata0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= data_output;
                    end
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gating write_enable with reset keeps an aborted access from touching memory
    assign write_enable = w_access & r_we & ~reset;
    assign read         = w_access & ~r_we;
    assign addr         = w_access ? r_addr : '0;
    assign data_input   = w_access ? r_wdata : '0;

    assign busy  = (r_state != S_IDLE);
    assign ack0  = (r_state == S_RESP) & ~r_gnt;
    assign ack1  = (r_state == S_RESP) & r_gnt;
    assign rdata = r_rdata;

endmodule
